// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM states
// and the datapath mux/ALU select codes.
package mips_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned STATE_W = 4;

  // Supported opcodes
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_JEX     = 4'd10,
    S_ORIEX   = 4'd11,
    S_LUIEX   = 4'd12,
    S_IMMWB   = 4'd13
  } state_t;

  // ALU operation
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Immediate extension mode
  localparam logic [1:0] IMM_SIGN  = 2'b00;
  localparam logic [1:0] IMM_ZERO  = 2'b01;
  localparam logic [1:0] IMM_UPPER = 2'b10;

  // True when the opcode has an execution path in the FSM
  function automatic logic op_supported(input logic [OP_W-1:0] op);
    case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_ADDIU,
      OP_ORI, OP_LUI, OP_LW, OP_SW: op_supported = 1'b1;
      default:                      op_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_outdec.sv
// State-to-control decode for the multicycle FSM. Controls are a pure function
// of the state; write strobes and illegal are additionally gated by reset.
// The FETCH load strobes are qualified by mem_ok (tied high unless memory
// wait states are enabled in the parent).
module multicycle_outdec
  import mips_pkg::*;
(
  input  state_t          state,
  input  logic            reset,
  input  logic            mem_ok,
  input  logic [OP_W-1:0] op,
  output logic            pcwrite,
  output logic            branch,
  output logic            irwrite,
  output logic            memwrite,
  output logic            regwrite,
  output logic            iord,
  output logic            memtoreg,
  output logic            regdst,
  output logic            alusrca,
  output logic [1:0]      alusrcb,
  output logic [1:0]      pcsrc,
  output logic [1:0]      aluop,
  output logic [1:0]      immsrc,
  output logic            illegal
);

  // Per-state control decode, then reset gating of the side-effecting strobes
  always_comb begin
    pcwrite  = 1'b0;
    branch   = 1'b0;
    irwrite  = 1'b0;
    memwrite = 1'b0;
    regwrite = 1'b0;
    iord     = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = SRCB_REG;
    pcsrc    = PCSRC_ALU;
    aluop    = ALUOP_ADD;
    immsrc   = IMM_SIGN;
    illegal  = 1'b0;

    case (state)
      S_FETCH: begin
        irwrite = mem_ok;
        pcwrite = mem_ok;
        alusrcb = SRCB_FOUR;
      end
      S_DECODE: begin
        alusrcb = SRCB_BRANCH;
        illegal = !op_supported(op);
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        iord = 1'b1;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = PCSRC_ALUOUT;
        branch  = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_ORIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        aluop   = ALUOP_OR;
        immsrc  = IMM_ZERO;
      end
      S_LUIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        immsrc  = IMM_UPPER;
      end
      S_IMMWB: begin
        regwrite = 1'b1;
      end
      S_JEX: begin
        pcwrite = 1'b1;
        pcsrc   = PCSRC_JUMP;
      end
      default: ;
    endcase

    // Reset aborts the instruction: no architectural side effects this cycle
    if (!reset) begin
      pcwrite  = 1'b0;
      branch   = 1'b0;
      irwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_fsm.sv
// Multicycle MIPS main control FSM: state register and next-state logic, with
// control decode in multicycle_outdec.
// Optional feature: define MULTICYCLE_FSM_MEMWAIT_EN to make FETCH, MEMRD and
// MEMWR wait for mem_rdy; otherwise mem_rdy is ignored.
module multicycle_fsm
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic               mem_rdy,
  output logic               pcwrite,
  output logic               branch,
  output logic               irwrite,
  output logic               memwrite,
  output logic               regwrite,
  output logic               iord,
  output logic               memtoreg,
  output logic               regdst,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [1:0]         aluop,
  output logic [1:0]         immsrc,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  state_t state_q;
  state_t state_d;
  logic   mem_ok;

`ifdef MULTICYCLE_FSM_MEMWAIT_EN
  assign mem_ok = mem_rdy;
`else
  logic unused_mem_rdy;
  assign unused_mem_rdy = mem_rdy;
  assign mem_ok         = 1'b1;
`endif

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ok ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:      state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_RTYPEEX;
          OP_BEQ:            state_d = S_BEQEX;
          OP_ADDI, OP_ADDIU: state_d = S_ADDIEX;
          OP_J:              state_d = S_JEX;
          OP_ORI:            state_d = S_ORIEX;
          OP_LUI:            state_d = S_LUIEX;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = mem_ok ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_d = mem_ok ? S_FETCH : S_MEMWR;
      S_RTYPEEX: state_d = S_ALUWB;
      S_ADDIEX,
      S_ORIEX,
      S_LUIEX:   state_d = S_IMMWB;
      default:   state_d = S_FETCH;
    endcase
  end

  assign state = STATE_W'(state_q);

  multicycle_outdec u_outdec (
    .state    (state_q),
    .reset    (reset),
    .mem_ok   (mem_ok),
    .op       (op),
    .pcwrite  (pcwrite),
    .branch   (branch),
    .irwrite  (irwrite),
    .memwrite (memwrite),
    .regwrite (regwrite),
    .iord     (iord),
    .memtoreg (memtoreg),
    .regdst   (regdst),
    .alusrca  (alusrca),
    .alusrcb  (alusrcb),
    .pcsrc    (pcsrc),
    .aluop    (aluop),
    .immsrc   (immsrc),
    .illegal  (illegal)
  );

endmodule

// File: tb/tb_multicycle_fsm.sv
// Directed bench for multicycle_fsm: walks each instruction class through its
// state sequence and compares state and the full control word every cycle
// against a hand-written per-state table. Also covers reset abort and, when
// MULTICYCLE_FSM_MEMWAIT_EN is defined, memory wait states.
module tb_multicycle_fsm;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic       mem_rdy;
  logic       pcwrite, branch, irwrite, memwrite, regwrite;
  logic       iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, pcsrc, aluop, immsrc;
  logic       illegal;
  logic [3:0] state;

  int n_cmp = 0;
  int n_err = 0;

  multicycle_fsm dut (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .mem_rdy  (mem_rdy),
    .pcwrite  (pcwrite),
    .branch   (branch),
    .irwrite  (irwrite),
    .memwrite (memwrite),
    .regwrite (regwrite),
    .iord     (iord),
    .memtoreg (memtoreg),
    .regdst   (regdst),
    .alusrca  (alusrca),
    .alusrcb  (alusrcb),
    .pcsrc    (pcsrc),
    .aluop    (aluop),
    .immsrc   (immsrc),
    .illegal  (illegal),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expectation
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs may be changed right after return
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  function automatic logic legal_op(input logic [5:0] o);
    return (o == 6'b000000) || (o == 6'b000010) || (o == 6'b000100) ||
           (o == 6'b001000) || (o == 6'b001001) || (o == 6'b001101) ||
           (o == 6'b001111) || (o == 6'b100011) || (o == 6'b101011);
  endfunction

  // Observed control word: {pcwrite,branch,irwrite,memwrite,regwrite,iord,
  // memtoreg,regdst,alusrca,alusrcb,pcsrc,aluop,immsrc,illegal}
  function automatic logic [17:0] obs_ctl();
    return {pcwrite, branch, irwrite, memwrite, regwrite, iord, memtoreg,
            regdst, alusrca, alusrcb, pcsrc, aluop, immsrc, illegal};
  endfunction

  // Expected control word from the per-state output table
  function automatic logic [17:0] exp_ctl(input int s, input logic rst_n,
                                          input logic rdy, input logic ill);
    logic pw, br, irw, mw, rw, io, m2r, rd, asa, il, rdy_eff;
    logic [1:0] asb, pcs, aop, imm;
    pw = 0; br = 0; irw = 0; mw = 0; rw = 0; io = 0; m2r = 0; rd = 0; asa = 0;
    asb = 2'b00; pcs = 2'b00; aop = 2'b00; imm = 2'b00;
`ifdef MULTICYCLE_FSM_MEMWAIT_EN
    rdy_eff = rdy;
`else
    rdy_eff = 1'b1 | rdy;
`endif
    il = ill & rst_n;
    case (s)
      0:  begin pw = rdy_eff; irw = rdy_eff; asb = 2'b01; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  io = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin io = 1; mw = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rd = 1; rw = 1; end
      8:  begin asa = 1; aop = 2'b01; pcs = 2'b01; br = 1; end
      9:  begin asa = 1; asb = 2'b10; end
      10: begin pw = 1; pcs = 2'b10; end
      11: begin asa = 1; asb = 2'b10; aop = 2'b11; imm = 2'b01; end
      12: begin asa = 1; asb = 2'b10; imm = 2'b10; end
      13: rw = 1;
      default: ;
    endcase
    if (!rst_n) begin pw = 0; br = 0; irw = 0; mw = 0; rw = 0; end
    return {pw, br, irw, mw, rw, io, m2r, rd, asa, asb, pcs, aop, imm, il};
  endfunction

  // Run one instruction from FETCH; seq lists the expected states, ending at
  // the next FETCH
  task automatic run_instr(input string name, input logic [5:0] o,
                           input int seq[6], input int n, input logic rdy);
    op = o;
    mem_rdy = rdy;
    for (int i = 0; i < n; i++) begin
      #1;
      check($sformatf("%s state[%0d]", name, i), 32'(state), 32'(seq[i]));
      check($sformatf("%s ctl[%0d]", name, i), 32'(obs_ctl()),
            32'(exp_ctl(seq[i], 1'b1, rdy, (seq[i] == 1) && !legal_op(o))));
      if (i < n - 1) cyc();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    op = 6'b100011;
    mem_rdy = 1'b1;
    cyc();
    cyc();

    // Reset state: FETCH with load strobes suppressed
    #1;
    check("reset state", 32'(state), 32'd0);
    check("reset ctl", 32'(obs_ctl()), 32'(exp_ctl(0, 1'b0, 1'b1, 1'b0)));
    check("reset pcwrite", 32'(pcwrite), 32'd0);
    reset = 1'b1;

    // Instruction classes with their latencies
    run_instr("lw",    6'b100011, '{0, 1, 2, 3, 4, 0}, 6, 1'b1);
    run_instr("sw",    6'b101011, '{0, 1, 2, 5, 0, 0}, 5, 1'b1);
    run_instr("rtype", 6'b000000, '{0, 1, 6, 7, 0, 0}, 5, 1'b1);
    run_instr("beq",   6'b000100, '{0, 1, 8, 0, 0, 0}, 4, 1'b1);
    run_instr("addi",  6'b001000, '{0, 1, 9, 13, 0, 0}, 5, 1'b1);
    run_instr("addiu", 6'b001001, '{0, 1, 9, 13, 0, 0}, 5, 1'b1);
    run_instr("j",     6'b000010, '{0, 1, 10, 0, 0, 0}, 4, 1'b1);
    run_instr("ori",   6'b001101, '{0, 1, 11, 13, 0, 0}, 5, 1'b1);
    run_instr("lui",   6'b001111, '{0, 1, 12, 13, 0, 0}, 5, 1'b1);
    run_instr("ill",   6'b111111, '{0, 1, 0, 0, 0, 0}, 3, 1'b1);
    run_instr("ill2",  6'b010000, '{0, 1, 0, 0, 0, 0}, 3, 1'b1);

`ifndef MULTICYCLE_FSM_MEMWAIT_EN
    // mem_rdy is ignored without wait states
    run_instr("lw_nordy", 6'b100011, '{0, 1, 2, 3, 4, 0}, 6, 1'b0);
    mem_rdy = 1'b1;
`endif

    // Reset in MEMWB aborts the register write
    op = 6'b100011;
    cyc(); cyc(); cyc(); cyc();
    #1;
    check("rst_wb pre state", 32'(state), 32'd4);
    reset = 1'b0;
    #1;
    check("rst_wb regwrite", 32'(regwrite), 32'd0);
    check("rst_wb ctl", 32'(obs_ctl()), 32'(exp_ctl(4, 1'b0, 1'b1, 1'b0)));
    cyc();
    reset = 1'b1;
    #1;
    check("rst_wb post state", 32'(state), 32'd0);

    // Reset in MEMWR aborts the memory write
    op = 6'b101011;
    cyc(); cyc(); cyc();
    #1;
    check("rst_wr pre state", 32'(state), 32'd5);
    reset = 1'b0;
    #1;
    check("rst_wr memwrite", 32'(memwrite), 32'd0);
    cyc();
    reset = 1'b1;
    #1;
    check("rst_wr post state", 32'(state), 32'd0);

    // Reset in DECODE with an unsupported opcode suppresses illegal
    op = 6'b111111;
    cyc();
    #1;
    check("rst_dec pre state", 32'(state), 32'd1);
    reset = 1'b0;
    #1;
    check("rst_dec illegal", 32'(illegal), 32'd0);
    cyc();
    reset = 1'b1;
    #1;
    check("rst_dec post state", 32'(state), 32'd0);

`ifdef MULTICYCLE_FSM_MEMWAIT_EN
    // FETCH holds without mem_rdy and withholds its load strobes
    op = 6'b101011;
    mem_rdy = 1'b0;
    #1;
    check("wait fetch irwrite", 32'(irwrite), 32'd0);
    check("wait fetch pcwrite", 32'(pcwrite), 32'd0);
    cyc();
    #1;
    check("wait fetch hold", 32'(state), 32'd0);
    mem_rdy = 1'b1;
    #1;
    check("wait fetch irwrite rdy", 32'(irwrite), 32'd1);
    cyc(); cyc();
    mem_rdy = 1'b0;
    cyc();
    // MEMWR: three stalled cycles plus the completing one
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("wait memwr state[%0d]", k), 32'(state), 32'd5);
      check($sformatf("wait memwr memwrite[%0d]", k), 32'(memwrite), 32'd1);
      cyc();
    end
    mem_rdy = 1'b1;
    #1;
    check("wait memwr state[3]", 32'(state), 32'd5);
    check("wait memwr memwrite[3]", 32'(memwrite), 32'd1);
    cyc();
    #1;
    check("wait memwr done", 32'(state), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
